// File: rtl/decimal_entry_unit.sv
// ---------------------------------------------------------------------------
// decimal_entry_unit
//
// Keypad-side front end for the calculator. Collects an optional sign and up
// to three decimal digits from single-cycle strobes, then converts the signed
// decimal entry into an 8-bit two's-complement operand with a fixed-latency
// reverse double-dabble engine. A one-cycle VALID pulse presents the result
// together with an out-of-range flag. The digit buffer is echoed so the
// display can show the entry while it is being typed.
//
// Ports:
//   CLOCK_50      in   1  system clock, rising edge
//   RST           in   1  synchronous active-high reset
//   DIGIT         in   4  digit value, qualified by DIGIT_STB
//   DIGIT_STB     in   1  pulse: append DIGIT to the buffer
//   NEG_STB       in   1  pulse: toggle entry sign
//   ENTER_STB     in   1  pulse: start conversion
//   CLEAR_STB     in   1  pulse: discard entry
//   VALUE         out  8  two's-complement result, held until next result
//   VALID         out  1  pulse: VALUE/OVF just updated
//   OVF           out  1  last result was outside -128..127
//   BUSY          out  1  conversion in progress
//   ENT_HUNDREDS  out  4  entry buffer hundreds digit
//   ENT_TENS      out  4  entry buffer tens digit
//   ENT_ONES      out  4  entry buffer ones digit
//   ENT_NEG       out  1  entry sign (1 = negative)
// ---------------------------------------------------------------------------
module decimal_entry_unit #(
  parameter int NDIG     = 3,
  parameter int CONV_CYC = 10
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic [3:0] DIGIT,
  input  logic       DIGIT_STB,
  input  logic       NEG_STB,
  input  logic       ENTER_STB,
  input  logic       CLEAR_STB,
  output logic [7:0] VALUE,
  output logic       VALID,
  output logic       OVF,
  output logic       BUSY,
  output logic [3:0] ENT_HUNDREDS,
  output logic [3:0] ENT_TENS,
  output logic [3:0] ENT_ONES,
  output logic       ENT_NEG
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_CONV,
    S_CHECK
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [3:0]  r_hundreds;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic [1:0]  r_count;
  logic        r_neg;
  logic [21:0] r_shift;
  logic [3:0]  r_iter;
  logic [7:0]  r_value;
  logic        r_valid;
  logic        r_ovf;

  logic        w_doClear;
  logic        w_doEnter;
  logic        w_doNeg;
  logic        w_doDigit;
  logic        w_busy;
  logic        w_check;
  logic [21:0] w_shifted;
  logic [21:0] w_shiftNext;
  logic [9:0]  w_mag;
  logic [7:0]  w_resultValue;
  logic        w_resultOvf;

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. Strobes are only honoured while an entry is open, and
  // only the highest-priority one (CLEAR > ENTER > NEG > DIGIT) takes effect.
  always_comb begin
    w_stateNext = r_state;
    w_doClear   = 1'b0;
    w_doEnter   = 1'b0;
    w_doNeg     = 1'b0;
    w_doDigit   = 1'b0;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (CLEAR_STB) begin
          w_doClear   = 1'b1;
          w_stateNext = S_IDLE;
        end else if (ENTER_STB) begin
          w_doEnter   = 1'b1;
          w_stateNext = S_CONV;
        end else if (NEG_STB) begin
          w_doNeg     = 1'b1;
          w_stateNext = S_ENTRY;
        end else if (DIGIT_STB) begin
          w_doDigit   = 1'b1;
          w_stateNext = S_ENTRY;
        end
      end
      S_CONV: begin
        if (r_iter == 4'(CONV_CYC - 1)) begin
          w_stateNext = S_CHECK;
        end
      end
      S_CHECK: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    w_busy  = (r_state == S_CONV) || (r_state == S_CHECK);
    w_check = (r_state == S_CHECK);
  end

  // One reverse double-dabble step: shift the whole {BCD, BIN} word right,
  // then correct every BCD nibble that picked up a half-weight carry (>= 8).
  always_comb begin
    w_shifted   = r_shift >> 1;
    w_shiftNext = w_shifted;
    for (int i = 0; i < 3; i++) begin
      if (w_shifted[10 + 4*i +: 4] >= 4'd8) begin
        w_shiftNext[10 + 4*i +: 4] = w_shifted[10 + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Range check and sign application on the converted magnitude. -128 is the
  // only negative value whose magnitude does not fit in 7 bits.
  always_comb begin
    w_mag         = r_shift[9:0];
    w_resultValue = 8'h00;
    w_resultOvf   = 1'b1;
    if (!r_neg && (w_mag <= 10'd127)) begin
      w_resultValue = w_mag[7:0];
      w_resultOvf   = 1'b0;
    end else if (r_neg && (w_mag <= 10'd128)) begin
      w_resultValue = 8'h00 - w_mag[7:0];
      w_resultOvf   = 1'b0;
    end
  end

  // Entry buffer, conversion engine and result registers. The buffer is a
  // fixed three-digit shift register; extra digits and non-decimal codes are
  // dropped silently.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      r_hundreds <= 4'd0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_count    <= 2'd0;
      r_neg      <= 1'b0;
      r_shift    <= 22'd0;
      r_iter     <= 4'd0;
      r_value    <= 8'h00;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_doClear) begin
        r_hundreds <= 4'd0;
        r_tens     <= 4'd0;
        r_ones     <= 4'd0;
        r_count    <= 2'd0;
        r_neg      <= 1'b0;
      end else if (w_doEnter) begin
        r_shift <= {r_hundreds, r_tens, r_ones, 10'd0};
        r_iter  <= 4'd0;
      end else if (w_doNeg) begin
        r_neg <= ~r_neg;
      end else if (w_doDigit && (DIGIT <= 4'd9) && (r_count < 2'(NDIG))) begin
        r_hundreds <= r_tens;
        r_tens     <= r_ones;
        r_ones     <= DIGIT;
        r_count    <= r_count + 2'd1;
      end

      if (r_state == S_CONV) begin
        r_shift <= w_shiftNext;
        r_iter  <= r_iter + 4'd1;
      end

      if (w_check) begin
        r_value    <= w_resultValue;
        r_ovf      <= w_resultOvf;
        r_valid    <= 1'b1;
        r_hundreds <= 4'd0;
        r_tens     <= 4'd0;
        r_ones     <= 4'd0;
        r_count    <= 2'd0;
        r_neg      <= 1'b0;
      end
    end
  end

  assign VALUE        = r_value;
  assign VALID        = r_valid;
  assign OVF          = r_ovf;
  assign BUSY         = w_busy;
  assign ENT_HUNDREDS = r_hundreds;
  assign ENT_TENS     = r_tens;
  assign ENT_ONES     = r_ones;
  assign ENT_NEG      = r_neg;

endmodule
